// File: rtl/sw_debouncer_if.sv
// Switch conditioning bus: raw levels and event clear in, debounced levels and
// change/event flags out.
interface sw_debouncer_if #(parameter int N_SW = 5);
  logic [N_SW-1:0] sw_raw;
  logic            evt_clr;
  logic            sw0, sw1, sw2, sw3, sw4;
  logic            sw_changed;
  logic            sw_event;

  modport master (output sw_raw, evt_clr,
                  input  sw0, sw1, sw2, sw3, sw4, sw_changed, sw_event);
  modport slave  (input  sw_raw, evt_clr,
                  output sw0, sw1, sw2, sw3, sw4, sw_changed, sw_event);
endinterface

// File: rtl/sw_debouncer.sv
// Slide-switch debouncer: per-bit 2-flop synchronizer plus stability counter,
// with a registered change pulse and a sticky, software-clearable event flag.
module sw_debouncer_lane #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clock,
  input  logic resetn,
  input  logic raw,
  output logic out,
  output logic flip
);
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1, s2;
  logic [CW-1:0] cnt;

  // Asserted on the edge where this bit's output is about to take s2.
  assign flip = (s2 != out) && (cnt == CNT_MAX);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      cnt <= '0;
      out <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      if (s2 == out) begin
        cnt <= '0;
      end else if (flip) begin
        out <= s2;
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end
endmodule

module sw_debouncer #(
  parameter int N_SW            = 5,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input logic           clock,
  input logic           resetn,
  sw_debouncer_if.slave bus
);
  logic [N_SW-1:0] sw_raw;
  logic [N_SW-1:0] out;
  logic [N_SW-1:0] flip;
  logic            sw_changed_q;
  logic            sw_event_q;

  assign sw_raw = bus.sw_raw;

  for (genvar i = 0; i < N_SW; i++) begin : g_lane
    sw_debouncer_lane #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_lane (
      .clock  (clock),
      .resetn (resetn),
      .raw    (sw_raw[i]),
      .out    (out[i]),
      .flip   (flip[i])
    );
  end

  // A flip on the same edge as evt_clr keeps the flag set.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sw_changed_q <= 1'b0;
      sw_event_q   <= 1'b0;
    end else begin
      sw_changed_q <= |flip;
      sw_event_q   <= (|flip) | (sw_event_q & ~bus.evt_clr);
    end
  end

  assign bus.sw0        = out[0];
  assign bus.sw1        = out[1];
  assign bus.sw2        = out[2];
  assign bus.sw3        = out[3];
  assign bus.sw4        = out[4];
  assign bus.sw_changed = sw_changed_q;
  assign bus.sw_event   = sw_event_q;
endmodule

// File: tb/tb_sw_debouncer.sv
// Directed bench for sw_debouncer: startup, latency, glitch, bounce,
// event handshake and asynchronous reset mid-count.
module tb_sw_debouncer;
  logic clock  = 1'b0;
  logic resetn = 1'b0;
  int   errors = 0;
  int   checks = 0;

  sw_debouncer_if #(.N_SW(5)) bus ();

  sw_debouncer #(.N_SW(5), .DEBOUNCE_CYCLES(4)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [4:0] raw;
    logic       clr;
    int         n;
    logic [4:0] sw;
    logic       chg;
    logic       evt;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [4:0] sw_vec();
    return {bus.sw4, bus.sw3, bus.sw2, bus.sw1, bus.sw0};
  endfunction

  task automatic chk(input string name, input logic [4:0] got, input logic [4:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %b want %b", name, got, want);
    end
  endtask

  task automatic chk_all(input string name, input logic [4:0] sw, input logic chg, input logic evt);
    chk({name, ".sw"},  sw_vec(),               sw);
    chk({name, ".chg"}, {4'b0, bus.sw_changed}, {4'b0, chg});
    chk({name, ".evt"}, {4'b0, bus.sw_event},   {4'b0, evt});
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic void add(input logic [4:0] raw, input logic clr, input int n,
                              input logic [4:0] sw, input logic chg, input logic evt);
    vec_t v;
    v.raw = raw; v.clr = clr; v.n = n; v.sw = sw; v.chg = chg; v.evt = evt;
    tbl.push_back(v);
  endfunction

  initial begin
    bus.sw_raw  = 5'b10101;
    bus.evt_clr = 1'b0;

    // Held in reset with switches high: everything stays 0.
    repeat (3) tick();
    chk_all("reset", 5'b00000, 1'b0, 1'b0);
    resetn = 1'b1;
    repeat (5) tick();
    chk_all("start_e4", 5'b00000, 1'b0, 1'b0);
    tick();
    chk_all("start_e5", 5'b10101, 1'b1, 1'b1);
    tick();
    chk_all("start_e6", 5'b10101, 1'b0, 1'b1);

    // raw, clr, ticks, expected sw, sw_changed, sw_event after the last tick
    add(5'b10101, 1, 1, 5'b10101, 0, 0);  // clear event
    add(5'b00000, 0, 5, 5'b10101, 0, 0);  // three bits falling
    add(5'b00000, 0, 1, 5'b00000, 1, 1);
    add(5'b00000, 0, 1, 5'b00000, 0, 1);
    add(5'b00000, 1, 1, 5'b00000, 0, 0);
    add(5'b00010, 0, 5, 5'b00000, 0, 0);  // latency, bit1
    add(5'b00010, 0, 1, 5'b00010, 1, 1);
    add(5'b00010, 0, 1, 5'b00010, 0, 1);
    add(5'b00010, 1, 1, 5'b00010, 0, 0);
    add(5'b01010, 0, 3, 5'b00010, 0, 0);  // 3-cycle glitch on bit3
    add(5'b00010, 0, 8, 5'b00010, 0, 0);
    add(5'b01010, 0, 4, 5'b00010, 0, 0);  // 4-cycle pulse on bit3
    add(5'b00010, 0, 1, 5'b00010, 0, 0);
    add(5'b00010, 0, 1, 5'b01010, 1, 1);
    add(5'b00010, 0, 1, 5'b01010, 0, 1);
    add(5'b00010, 0, 3, 5'b00010, 1, 1);  // bit3 falls back
    add(5'b00010, 0, 1, 5'b00010, 0, 1);
    add(5'b00010, 1, 1, 5'b00010, 0, 0);
    add(5'b00011, 0, 1, 5'b00010, 0, 0);  // bounce on bit0: 1,0,1,1,0,1111
    add(5'b00010, 0, 1, 5'b00010, 0, 0);
    add(5'b00011, 0, 2, 5'b00010, 0, 0);
    add(5'b00010, 0, 1, 5'b00010, 0, 0);
    add(5'b00011, 0, 5, 5'b00010, 0, 0);
    add(5'b00011, 0, 1, 5'b00011, 1, 1);
    add(5'b00011, 1, 1, 5'b00011, 0, 0);
    add(5'b00001, 0, 5, 5'b00011, 0, 0);  // clear lands on flip edge
    add(5'b00001, 1, 1, 5'b00001, 1, 1);
    add(5'b00001, 0, 1, 5'b00001, 0, 1);

    foreach (tbl[i]) begin
      bus.sw_raw  = tbl[i].raw;
      bus.evt_clr = tbl[i].clr;
      repeat (tbl[i].n) tick();
      chk_all($sformatf("vec%0d", i), tbl[i].sw, tbl[i].chg, tbl[i].evt);
    end
    bus.evt_clr = 1'b0;

    // Async reset on the third counted mismatch of bit2.
    bus.sw_raw = 5'b00101;
    repeat (5) tick();
    chk_all("pre_rst", 5'b00001, 1'b0, 1'b1);
    #2 resetn = 1'b0;
    #1 chk_all("async_rst", 5'b00000, 1'b0, 1'b0);
    #1 resetn = 1'b1;
    repeat (5) tick();
    chk_all("post_rst_e4", 5'b00000, 1'b0, 1'b0);
    tick();
    chk_all("post_rst_e5", 5'b00101, 1'b1, 1'b1);
    tick();
    chk_all("post_rst_e6", 5'b00101, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
